// File: rtl/ysyx_23060025_key_lut_pipe.sv
// Purpose: programmable key->data lookup table with a registered, handshaked response and hit/miss statistics.
// Latency: a request accepted at edge N shows its response (rsp_valid=1) from edge N onward; one lookup per cycle.
// Backpressure: req_ready = !rsp_valid || rsp_ready; while stalled the response register holds every rsp_* field.
module ysyx_23060025_key_lut_pipe #(
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    parameter int CNT_LEN     = 16,
    localparam int IDX_LEN    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_LEN-1:0]  rsp_idx,
    output logic                rsp_multi,
    output logic [CNT_LEN-1:0]  hit_cnt,
    output logic [CNT_LEN-1:0]  miss_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};

    // Table storage: only the valid bits are reset; key/data are don't-care while invalid.
    logic [NR_KEY-1:0]   vld_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    state_e state_q, state_d;

    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_LEN-1:0]  rsp_idx_q, rsp_idx_d;
    logic                rsp_multi_q, rsp_multi_d;
    logic [CNT_LEN-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_LEN-1:0]  miss_cnt_q, miss_cnt_d;

    logic                accept;
    logic                wr_idx_ok;
    logic [NR_KEY-1:0]   match;
    logic                lk_hit;
    logic                lk_multi;
    logic [IDX_LEN-1:0]  lk_idx;
    logic [DATA_LEN-1:0] lk_data;

    // Ready depends only on the response register and the consumer, never on req_valid.
    assign req_ready = (state_q == ST_EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Out-of-range write indices are dropped (only reachable when NR_KEY is not a power of two).
    assign wr_idx_ok = ({{(32-IDX_LEN){1'b0}}, wr_idx} < 32'(NR_KEY));

    // Valid bits: reset and clear both invalidate everything; clear beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (clr) begin
            vld_q <= '0;
        end else if (wr_en && wr_idx_ok) begin
            vld_q[wr_idx] <= 1'b1;
        end
    end

    // Key/data fields: written without reset; a write suppressed by clr leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst && !clr && wr_en && wr_idx_ok) begin
            key_q[wr_idx]  <= wr_key;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Compare against pre-edge table state, so a same-cycle write is invisible to this lookup.
    always_comb begin
        for (int i = 0; i < NR_KEY; i++) begin
            match[i] = vld_q[i] && (key_q[i] == req_key);
        end
    end

    // Lowest-index priority select, plus a "second match seen" flag for the multi-hit indication.
    always_comb begin
        lk_hit   = 1'b0;
        lk_multi = 1'b0;
        lk_idx   = '0;
        lk_data  = (HAS_DEFAULT != 0) ? default_out : '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (match[i]) begin
                if (lk_hit) begin
                    lk_multi = 1'b1;
                end else begin
                    lk_hit  = 1'b1;
                    lk_idx  = i[IDX_LEN-1:0];
                    lk_data = data_q[i];
                end
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state: any accept fills; a drain without a new accept empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output FSM outputs.
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
    end

    // Response payload and counters next-state: everything updates only on an accept.
    always_comb begin
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_multi_d = rsp_multi_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (accept) begin
            rsp_data_d  = lk_data;
            rsp_hit_d   = lk_hit;
            rsp_idx_d   = lk_idx;
            rsp_multi_d = lk_multi;
            if (lk_hit) begin
                if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_LEN'(1);
            end else begin
                if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_LEN'(1);
            end
        end
    end

    // Response payload and counter registers; clr deliberately does not touch the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_multi_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_multi_q <= rsp_multi_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_multi = rsp_multi_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_23060025_key_lut_pipe.sv
// Purpose: directed self-checking bench for the key lookup table (4-bit counters to reach saturation quickly).
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the following edge.
// Backpressure: exercised by holding rsp_ready low with a queued request.
module tb_ysyx_23060025_key_lut_pipe;

    localparam int NR_KEY   = 8;
    localparam int KEY_LEN  = 7;
    localparam int DATA_LEN = 32;
    localparam int CNT_LEN  = 4;
    localparam int IDX_LEN  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic                wr_en;
    logic [IDX_LEN-1:0]  wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic [DATA_LEN-1:0] default_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;
    logic [IDX_LEN-1:0]  rsp_idx;
    logic                rsp_multi;
    logic [CNT_LEN-1:0]  hit_cnt;
    logic [CNT_LEN-1:0]  miss_cnt;

    int checks = 0;
    int errors = 0;
    logic [CNT_LEN-1:0] exp_hit;
    logic [CNT_LEN-1:0] exp_miss;

    always #5 clk = ~clk;

    ysyx_23060025_key_lut_pipe #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
        .HAS_DEFAULT(1), .CNT_LEN(CNT_LEN)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .default_out(default_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_multi(rsp_multi),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_hit();
        if (exp_hit != 4'hF) exp_hit = exp_hit + 4'd1;
    endtask

    task automatic bump_miss();
        if (exp_miss != 4'hF) exp_miss = exp_miss + 4'd1;
    endtask

    task automatic do_write(input logic [IDX_LEN-1:0] idx, input logic [KEY_LEN-1:0] key,
                            input logic [DATA_LEN-1:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_lookup(input logic [KEY_LEN-1:0] key);
        req_valid = 1'b1; req_key = key;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_during got %b want 1", req_ready); end
        step();
        rst = 1'b0;
        step();
        exp_hit = '0; exp_miss = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++;
        if (rsp_data !== 32'h0 || rsp_hit !== 1'b0 || rsp_idx !== 3'd0 || rsp_multi !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_fields got data=%h hit=%b idx=%0d multi=%b want 0", rsp_data, rsp_hit, rsp_idx, rsp_multi);
        end
        checks++;
        if (hit_cnt !== 4'h0 || miss_cnt !== 4'h0) begin
            errors++; $display("FAIL reset_counters got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_after got %b want 1", req_ready); end
    endtask

    task automatic test_post_reset_miss();
        rsp_ready = 1'b1;
        default_out = 32'hDEAD_BEEF;
        do_lookup(7'h13);
        bump_miss();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== 32'hDEAD_BEEF || rsp_idx !== 3'd0) begin
            errors++; $display("FAIL post_reset_miss got v=%b hit=%b data=%h idx=%0d want 1/0/deadbeef/0", rsp_valid, rsp_hit, rsp_data, rsp_idx);
        end
        checks++;
        if (miss_cnt !== exp_miss) begin errors++; $display("FAIL post_reset_miss_cnt got %0d want %0d", miss_cnt, exp_miss); end
    endtask

    task automatic test_single_hit();
        do_write(3'd5, 7'h33, 32'h0000_00B3);
        do_lookup(7'h33);
        bump_hit();
        checks++;
        if (rsp_hit !== 1'b1 || rsp_idx !== 3'd5 || rsp_data !== 32'hB3 || rsp_multi !== 1'b0) begin
            errors++; $display("FAIL single_hit got hit=%b idx=%0d data=%h multi=%b want 1/5/b3/0", rsp_hit, rsp_idx, rsp_data, rsp_multi);
        end
        checks++;
        if (hit_cnt !== exp_hit) begin errors++; $display("FAIL single_hit_cnt got %0d want %0d", hit_cnt, exp_hit); end
    endtask

    task automatic test_same_cycle_then_multi();
        wr_en = 1'b1; wr_idx = 3'd2; wr_key = 7'h33; wr_data = 32'h22;
        req_valid = 1'b1; req_key = 7'h33;
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        bump_hit();
        checks++;
        if (rsp_idx !== 3'd5 || rsp_data !== 32'hB3 || rsp_multi !== 1'b0) begin
            errors++; $display("FAIL same_cycle_write got idx=%0d data=%h multi=%b want 5/b3/0", rsp_idx, rsp_data, rsp_multi);
        end
        do_lookup(7'h33);
        bump_hit();
        checks++;
        if (rsp_hit !== 1'b1 || rsp_idx !== 3'd2 || rsp_data !== 32'h22 || rsp_multi !== 1'b1) begin
            errors++; $display("FAIL multi_hit got hit=%b idx=%0d data=%h multi=%b want 1/2/22/1", rsp_hit, rsp_idx, rsp_data, rsp_multi);
        end
        checks++;
        if (hit_cnt !== exp_hit) begin errors++; $display("FAIL multi_hit_cnt got %0d want %0d", hit_cnt, exp_hit); end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_to_empty got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        // Keys 1..3 all miss; each tagged by default_out so order is visible in rsp_data.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_key = 7'h01; default_out = 32'h101;
        step();
        bump_miss();
        req_key = 7'h02; default_out = 32'h102;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'h101 || rsp_hit !== 1'b0) begin
                errors++; $display("FAIL stall_cycle%0d got rdy=%b v=%b data=%h want 0/1/101", c, req_ready, rsp_valid, rsp_data);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", req_ready); end
        step();
        bump_miss();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h102) begin
            errors++; $display("FAIL bp_resp2 got v=%b data=%h want 1/102", rsp_valid, rsp_data);
        end
        req_key = 7'h03; default_out = 32'h103;
        step();
        bump_miss();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h103) begin
            errors++; $display("FAIL bp_resp3 got v=%b data=%h want 1/103", rsp_valid, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || miss_cnt !== exp_miss) begin
            errors++; $display("FAIL bp_end got v=%b miss=%0d want 0/%0d", rsp_valid, miss_cnt, exp_miss);
        end
    endtask

    task automatic test_clear_vs_write();
        default_out = 32'hC0DE_0000;
        clr = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_key = 7'h01; wr_data = 32'h1;
        step();
        clr = 1'b0; wr_en = 1'b0;
        checks++;
        if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
            errors++; $display("FAIL clr_counters got hit=%0d miss=%0d want %0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
        do_lookup(7'h01);
        bump_miss();
        checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 32'hC0DE_0000) begin
            errors++; $display("FAIL clr_beats_write got hit=%b data=%h want 0/c0de0000", rsp_hit, rsp_data);
        end
        do_lookup(7'h33);
        bump_miss();
        checks++;
        if (rsp_hit !== 1'b0 || hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
            errors++; $display("FAIL clr_invalidates got hit=%b hc=%0d mc=%0d want 0/%0d/%0d", rsp_hit, hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    task automatic test_saturation_and_reset();
        do_write(3'd1, 7'h55, 32'h77);
        req_valid = 1'b1; req_key = 7'h55;
        for (int n = 0; n < 20; n++) begin
            step();
            bump_hit();
        end
        req_valid = 1'b0;
        checks++;
        if (hit_cnt !== 4'hF || exp_hit !== 4'hF) begin
            errors++; $display("FAIL hit_saturation got %h want f", hit_cnt);
        end
        checks++;
        if (rsp_hit !== 1'b1 || rsp_idx !== 3'd1 || rsp_data !== 32'h77) begin
            errors++; $display("FAIL back_to_back_hit got hit=%b idx=%0d data=%h want 1/1/77", rsp_hit, rsp_idx, rsp_data);
        end
        // Stall a response, then reset in the middle of the stall.
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b1; req_key = 7'h55;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL pre_reset_stall got v=%b rdy=%b want 1/0", rsp_valid, req_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_hit = '0; exp_miss = '0;
        checks++;
        if (rsp_valid !== 1'b0 || hit_cnt !== 4'h0 || miss_cnt !== 4'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_stall_reset got v=%b hc=%0d mc=%0d rdy=%b want 0/0/0/1", rsp_valid, hit_cnt, miss_cnt, req_ready);
        end
        rsp_ready = 1'b1;
        default_out = 32'h5A5A_5A5A;
        do_lookup(7'h55);
        bump_miss();
        checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 32'h5A5A_5A5A || miss_cnt !== exp_miss) begin
            errors++; $display("FAIL reset_invalidates got hit=%b data=%h mc=%0d want 0/5a5a5a5a/%0d", rsp_hit, rsp_data, miss_cnt, exp_miss);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
        req_valid = 1'b0; req_key = '0; default_out = '0; rsp_ready = 1'b0;
        exp_hit = '0; exp_miss = '0;
        test_reset();
        test_post_reset_miss();
        test_single_hit();
        test_same_cycle_then_multi();
        test_backpressure();
        test_clear_vs_write();
        test_saturation_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
